// File: rtl/sd_lane_shifter.sv
`default_nettype none
// ============================================================================
// Module      : sd_lane_shifter
// Description : SD bus CMD/DAT serialiser/deserialiser. Shifts a WIDTH-bit
//               word out MSB-first on 1 or 4 lanes while shifting line data
//               in, one bit-time per shift_en_i strobe. Transmit words enter
//               through a one-word holding buffer so words stream gaplessly.
// Ports       : clk_i, rstn_i        - clock, async active-low reset
//               enable_i             - run (1) / return to IDLE (0)
//               mode_4bit_i          - lane mode, latched on IDLE->ACTIVE
//               shift_en_i           - one SD bit-time strobe
//               tx_data_i/valid_i    - transmit word handshake input
//               tx_ready_o           - holding buffer empty
//               tx_underrun_o        - word boundary found buffer empty
//               dat_i / dat_o        - sampled line values / line drive
//               rx_data_o/valid_o    - received word and its strobe
//               busy_o               - shifter is ACTIVE
// Revision    : 1.0 - initial release
// ============================================================================
module sd_lane_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             enable_i,
    input  logic             mode_4bit_i,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             tx_underrun_o,
    input  logic [3:0]       dat_i,
    output logic [3:0]       dat_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             busy_o
);

    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_1 = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  LAST_4 = CW'(WIDTH / 4 - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] sreg_q,     sreg_d;
    logic [WIDTH-1:0] buf_q,      buf_d;
    logic             buf_full_q, buf_full_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             mode_q,     mode_d;
    logic [WIDTH-1:0] rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             underrun_q, underrun_d;

    logic             w_accept;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_shift1;
    logic [WIDTH-1:0] w_shift4;
    logic [WIDTH-1:0] w_shifted;

    assign w_accept = tx_valid_i && !buf_full_q;
    assign w_last   = mode_q ? (cnt_q == LAST_4) : (cnt_q == LAST_1);
    assign w_shift1 = {sreg_q[WIDTH-2:0], dat_i[0]};

    // A 4-bit word is replaced entirely by one 4-lane shift.
    generate
        if (WIDTH == 4) begin : g_shift4_whole
            assign w_shift4 = dat_i;
        end else begin : g_shift4_concat
            assign w_shift4 = {sreg_q[WIDTH-5:0], dat_i};
        end
    endgenerate

    assign w_shifted = mode_q ? w_shift4 : w_shift1;

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        w_load     = 1'b0;

        case (state_q)
            IDLE: begin
                // Strobes in the entry cycle are ignored: the load owns sreg.
                if (enable_i) begin
                    state_d = ACTIVE;
                    w_load  = 1'b1;
                    cnt_d   = '0;
                    mode_d  = mode_4bit_i;
                end
            end
            ACTIVE: begin
                // Disable wins over a coincident strobe; partial word dropped.
                if (!enable_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (shift_en_i) begin
                    sreg_d = w_shifted;
                    if (w_last) begin
                        rx_data_d  = w_shifted;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        w_load     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load overrides the shift result; an empty buffer sends idle-high.
        if (w_load) begin
            if (buf_full_q) begin
                sreg_d     = buf_q;
                buf_full_d = 1'b0;
            end else begin
                sreg_d     = '1;
                underrun_d = 1'b1;
            end
        end

        // Accept only when empty, so this never collides with a load that
        // consumes the buffer in the same cycle.
        if (w_accept) begin
            buf_d      = tx_data_i;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            sreg_q     <= '1;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign busy_o        = (state_q == ACTIVE);
    assign tx_ready_o    = !buf_full_q;
    assign tx_underrun_o = underrun_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;

    // Unused lanes idle high; the MSB end of sreg is always the bit on the line.
    assign dat_o = (state_q == IDLE) ? 4'hF :
                   mode_q            ? sreg_q[WIDTH-1 -: 4] :
                                       {3'b111, sreg_q[WIDTH-1]};

endmodule
`default_nettype wire

// File: tb/tb_sd_lane_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_lane_shifter
// Description : Self-checking bench for sd_lane_shifter (WIDTH=8). A word/
//               position level reference model predicts every output each
//               cycle; directed scenarios pin the model with literal values,
//               followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_lane_shifter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         enable = 1'b0;
    logic         mode = 1'b0;
    logic         shift_en = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic [3:0]   dat_drv = 4'hF;
    logic         loop = 1'b0;

    logic         tx_ready;
    logic         tx_underrun;
    logic [3:0]   dat_i;
    logic [3:0]   dat_o;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;

    // Optional direct loopback of lane 0 onto itself.
    assign dat_i = loop ? {dat_drv[3:1], dat_o[0]} : dat_drv;

    sd_lane_shifter #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .enable_i     (enable),
        .mode_4bit_i  (mode),
        .shift_en_i   (shift_en),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .tx_underrun_o(tx_underrun),
        .dat_i        (dat_i),
        .dat_o        (dat_o),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (word + bit position view) ----------
    bit           m_active, m_mode, m_buf_full, m_rx_valid, m_un;
    logic [W-1:0] m_word, m_buf, m_rx, m_rx_data;
    int           m_pos;

    function automatic logic [3:0] exp_dat();
        logic [W-1:0] t;
        if (!m_active) return 4'hF;
        if (m_mode) begin
            t = m_word >> (W - 4 - 4 * m_pos);
            return t[3:0];
        end
        t = m_word >> (W - 1 - m_pos);
        return {3'b111, t[0]};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 0; m_mode = 0; m_buf_full = 0; m_buf = '0;
            m_word = '1; m_pos = 0; m_rx = '0; m_rx_data = '0;
            m_rx_valid = 0; m_un = 0;
        end else begin : model_step
            bit acc;
            bit do_load;
            acc = tx_valid && !m_buf_full;
            do_load = 0;
            m_rx_valid = 0;
            m_un = 0;
            if (!m_active) begin
                if (enable) begin
                    m_active = 1; m_mode = mode; m_pos = 0; m_rx = '0; do_load = 1;
                end
            end else if (!enable) begin
                m_active = 0; m_pos = 0; m_rx = '0;
            end else if (shift_en) begin
                if (m_mode) m_rx = (m_rx << 4) | W'(dat_i);
                else        m_rx = (m_rx << 1) | W'(dat_i[0]);
                m_pos++;
                if (m_pos == (m_mode ? W / 4 : W)) begin
                    m_rx_data = m_rx; m_rx_valid = 1; m_pos = 0; m_rx = '0; do_load = 1;
                end
            end
            if (do_load) begin
                if (m_buf_full) begin m_word = m_buf; m_buf_full = 0; end
                else begin m_word = '1; m_un = 1; end
            end
            if (acc) begin m_buf = tx_data; m_buf_full = 1; end
        end
    end

    // ---------------- per-cycle compare + observation log ----------------
    logic [W-1:0] rxq[$];
    int           un_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (rstn) begin
            check("busy",     busy,        m_active);
            check("tx_ready", tx_ready,    !m_buf_full);
            check("dat_o",    dat_o,       exp_dat());
            check("rx_valid", rx_valid,    m_rx_valid);
            check("underrun", tx_underrun, m_un);
            check("rx_data",  rx_data,     m_rx_data);
            if (rx_valid) rxq.push_back(rx_data);
            if (tx_underrun) un_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe();
        shift_en = 1'b1;
        step();
        shift_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, un0;
        logic [7:0]  seq;
        logic [15:0] nib;

        // ---- reset values ----
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_dat_o", dat_o, 4'hF);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_pulses", {rx_valid, tx_underrun}, 0);
        rstn = 1'b1;
        step();

        // ---- 1-lane loopback of 0xA5, strobe every 3rd cycle ----
        tx_data = 8'hA5; tx_valid = 1; step(); tx_valid = 0;
        loop = 1; mode = 0; enable = 1; step();
        base = rxq.size();
        seq[7] = dat_o[0];
        for (int i = 0; i < 8; i++) begin
            step(); step(); strobe();
            if (i < 7) seq[6 - i] = dat_o[0];
        end
        check("t1_bits", seq, 8'hA5);
        check("t1_rx_count", 32'(rxq.size() - base), 1);
        // Direct loop: each strobe samples the bit currently driven.
        if (rxq.size() > base) check("t1_rx_word", rxq[base], 8'hA5);
        enable = 0; loop = 0; step();

        // ---- 4-lane, 0x3C then 0x96 back-to-back, dat_i = 7 ----
        base = rxq.size();
        dat_drv = 4'h7;
        tx_data = 8'h3C; tx_valid = 1; step();
        tx_data = 8'h96;
        mode = 1; enable = 1; step();
        nib[15:12] = dat_o;
        step(); tx_valid = 0;
        strobe(); nib[11:8] = dat_o;
        strobe(); nib[7:4]  = dat_o;
        strobe(); nib[3:0]  = dat_o;
        strobe();
        check("t2_nibbles", nib, 16'h3C96);
        check("t2_rx_count", 32'(rxq.size() - base), 2);
        if (rxq.size() >= base + 2) begin
            check("t2_rx_word0", rxq[base], 8'h77);
            check("t2_rx_word1", rxq[base + 1], 8'h77);
        end
        enable = 0; mode = 0; step();

        // ---- underrun: enable with empty buffer ----
        base = rxq.size(); un0 = un_cnt;
        enable = 1; step();
        check("t3_dat_o", dat_o, 4'hF);
        for (int i = 0; i < 16; i++) begin
            dat_drv = 4'($urandom);
            strobe();
        end
        enable = 0; step();
        check("t3_underruns", 32'(un_cnt - un0), 3);
        check("t3_rx_count", 32'(rxq.size() - base), 2);

        // ---- mode change mid-word ----
        base = rxq.size();
        mode = 0; enable = 1; step();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) mode = 1;
            strobe();
            if (i == 6) check("t4_no_early_rx", 32'(rxq.size() - base), 0);
        end
        check("t4_rx_after_8", 32'(rxq.size() - base), 1);
        enable = 0; step();
        enable = 1; step();
        strobe(); strobe();
        check("t4_rx_4lane", 32'(rxq.size() - base), 2);
        enable = 0; mode = 0; step();

        // ---- drop enable after 5 of 8 bits ----
        tx_data = 8'hC3; tx_valid = 1; step(); tx_valid = 0;
        enable = 1; step();
        tx_data = 8'h5E; tx_valid = 1; step(); tx_valid = 0;
        base = rxq.size();
        repeat (5) strobe();
        enable = 0; step();
        check("t5_dat_o", dat_o, 4'hF);
        check("t5_busy", busy, 0);
        check("t5_buf_kept", tx_ready, 0);
        check("t5_no_rx", 32'(rxq.size() - base), 0);
        enable = 1; step();
        seq[7] = dat_o[0];
        for (int i = 0; i < 7; i++) begin
            strobe();
            seq[6 - i] = dat_o[0];
        end
        strobe();
        check("t5_word", seq, 8'h5E);
        check("t5_rx_count", 32'(rxq.size() - base), 1);
        enable = 0; step();

        // ---- asynchronous reset mid-word with full buffer ----
        tx_data = 8'h81; tx_valid = 1; step(); tx_valid = 0;
        enable = 1; step();
        tx_data = 8'h42; tx_valid = 1; step(); tx_valid = 0;
        repeat (3) strobe();
        rstn = 0; #1;
        check("t6_busy", busy, 0);
        check("t6_dat_o", dat_o, 4'hF);
        check("t6_tx_ready", tx_ready, 1);
        check("t6_rx_data", rx_data, 0);
        check("t6_pulses", {rx_valid, tx_underrun}, 0);
        enable = 0; step();
        rstn = 1;
        base = rxq.size(); un0 = un_cnt;
        repeat (5) step();
        check("t6_no_rx", 32'(rxq.size() - base), 0);
        check("t6_no_underrun", 32'(un_cnt - un0), 0);

        // ---- randomized run ----
        for (int c = 0; c < 3000; c++) begin
            enable   = ($urandom_range(0, 99) < 95);
            mode     = 1'($urandom);
            shift_en = 1'($urandom);
            tx_valid = 1'($urandom);
            tx_data  = W'($urandom);
            dat_drv  = 4'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                rstn = 0;
                step();
                rstn = 1;
            end else begin
                step();
            end
        end
        shift_en = 0; tx_valid = 0; enable = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
